output_blk: RTL and testbench

OUTPUT_BLK -- requirements
Module: output_blk

---
 rtl/output_blk_pkg.sv | 21 ++
 rtl/output_blk_uart_tx.sv | 138 +++++++++++++
 rtl/output_blk.sv | 82 ++++++++
 tb/tb_output_blk.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_blk_pkg.sv
// Shared types and constants for the output_blk UART transmit path.
// Optional feature macro: OUTPUT_BLK_PARITY_EN (adds an even-parity bit).
package output_blk_pkg;

  localparam int DATA_W = 8;

  // Serializer states; PARITY is only entered when the parity bit is built in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/output_blk_uart_tx.sv
// uart_tx: byte serializer producing an idle-high UART frame.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Optional feature macro: OUTPUT_BLK_PARITY_EN (inserts the parity bit).
// The tx register follows the state one cycle behind, so a byte accepted
// on edge N shows its start bit from edge N+1 onward.
module uart_tx
  import output_blk_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              ready
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state, state_d;
  logic [CNT_W-1:0]  cyc_cnt, cyc_cnt_d;
  logic [IDX_W-1:0]  bit_idx, bit_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tx_d;
  logic              bit_done;

  assign bit_done = (cyc_cnt == CNT_LAST);

  // Next-state, counter and line-level logic for the frame sequencer.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    cyc_cnt_d = cyc_cnt;
    bit_idx_d = bit_idx;
    data_d    = data_q;
    tx_d      = 1'b1;
    ready     = 1'b0;

    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d   = START;
          cyc_cnt_d = '0;
          data_d    = data;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d   = DATA;
          cyc_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end

      DATA: begin
        tx_d = data_q[bit_idx];
        if (bit_done) begin
          cyc_cnt_d = '0;
          if (bit_idx == IDX_LAST) begin
`ifdef OUTPUT_BLK_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end

`ifdef OUTPUT_BLK_PARITY_EN
      PARITY: begin
        tx_d = even_parity(data_q);
        if (bit_done) begin
          state_d   = STOP;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          // Last stop cycle: chain straight into the next frame if one waits.
          ready     = 1'b1;
          cyc_cnt_d = '0;
          if (start) begin
            state_d = START;
            data_d  = data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        cyc_cnt_d = '0;
      end
    endcase
  end

  // State, counters, held byte and the registered line output.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      cyc_cnt <= cyc_cnt_d;
      bit_idx <= bit_idx_d;
      data_q  <= data_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: rtl/output_blk.sv
// output_blk: byte queue feeding a UART serializer (uart_tx).
// Writes are level-sampled on set; a write while full is dropped.
// Optional feature macro: OUTPUT_BLK_PARITY_EN (even-parity bit in each frame).
module output_blk
  import output_blk_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD       = 10_000_000,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [DATA_W-1:0] in,
  output logic              tx,
  output logic              full
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int PTR_W        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ready;

  // Pointers wrap explicitly so FIFO_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // full blocks the write even when a pop frees a slot in the same cycle.
  assign push  = set && !full;
  // The serializer only takes a byte when one is present.
  assign pop   = ready && !empty;

  // Queue storage write port.
  // NOTE: the storage array has no reset; count and pointers define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .start (pop),
    .data  (mem[rd_ptr]),
    .tx    (tx),
    .ready (ready)
  );

endmodule

// File: tb/tb_output_blk.sv
// Self-checking bench for output_blk.
// A queue-and-waveform model predicts tx/full on every cycle; a line decoder
// recovers bytes, and directed scenarios pin the model with literal values.
// Build with OUTPUT_BLK_PARITY_EN defined to exercise the parity frame.
module tb_output_blk;

  localparam int FIFO_DEPTH = 4;
  localparam int BAUD       = 10_000_000;
  localparam int CLK_FREQ   = 100_000_000;
  localparam int CPB        = CLK_FREQ / BAUD;
`ifdef OUTPUT_BLK_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic       clk;
  logic       rst;
  logic       set;
  logic [7:0] din;
  logic       tx;
  logic       full;

  int checks = 0;
  int errors = 0;

  output_blk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD       (BAUD),
    .CLK_FREQ   (CLK_FREQ)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .set  (set),
    .in   (din),
    .tx   (tx),
    .full (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_bytes: bytes waiting in the queue. m_wave: tx level after each future edge.
  logic [7:0] m_bytes[$];
  logic       m_wave[$];
  logic       exp_tx   = 1'b1;
  logic       exp_full = 1'b0;
  logic       m_rst    = 1'b1;
  logic       chk_en   = 1'b0;

  always @(posedge clk) begin
    logic       full_pre;
    logic [7:0] b;
    m_rst = rst;
    if (rst) begin
      m_bytes.delete();
      m_wave.delete();
      exp_tx   = 1'b1;
      exp_full = 1'b0;
    end else begin
      full_pre = (m_bytes.size() == FIFO_DEPTH);
      exp_tx   = (m_wave.size() > 0) ? m_wave.pop_front() : 1'b1;
      // Line free for the cycle after this edge and a byte waits: start a frame.
      if (m_wave.size() == 0 && m_bytes.size() > 0) begin
        b = m_bytes.pop_front();
        repeat (CPB) m_wave.push_back(1'b0);
        for (int j = 0; j < 8; j++) repeat (CPB) m_wave.push_back(b[j]);
`ifdef OUTPUT_BLK_PARITY_EN
        repeat (CPB) m_wave.push_back(^b);
`endif
        repeat (CPB) m_wave.push_back(1'b1);
      end
      if (set && !full_pre) m_bytes.push_back(din);
      exp_full = (m_bytes.size() == FIFO_DEPTH);
    end
    chk_en = 1'b1;
  end

  // Compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", {31'd0, tx}, {31'd0, exp_tx});
      check("model_full", {31'd0, full}, {31'd0, exp_full});
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  int         rx_cnt = -1;
  logic [7:0] rx_sh;

  always @(negedge clk) begin
    int j;
    if (m_rst) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (tx === 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        j = rx_cnt / CPB;
        if (j >= 1 && j <= 8) rx_sh[j-1] = tx;
      end
      if (rx_cnt == FRAME_CYC - 1) begin
        rx_q.push_back(rx_sh);
        rx_cnt = -1;
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Write one byte into an idle block and check the line against a literal frame.
  task automatic send_and_check(input logic [7:0] b, input logic [10:0] pat, input string name);
    set = 1'b1;
    din = b;
    @(negedge clk);
    set = 1'b0;
    @(negedge clk);
    check({name, "_latency_high"}, {31'd0, tx}, 32'd1);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      check({name, "_bit"}, {31'd0, tx}, {31'd0, pat[k / CPB]});
    end
    @(negedge clk);
    check({name, "_idle_after"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic check_rx(input logic [7:0] exp_b[], input string name);
    check({name, "_count"}, rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) begin
      check({name, "_byte"}, (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF, {24'd0, exp_b[i]});
    end
  endtask

  logic [10:0] pat55;
  logic [7:0]  burst_b[];
  logic [7:0]  held_b[];

  initial begin
    rst = 1'b1;
    set = 1'b0;
    din = 8'h00;

    // Reset held 10 cycles: line high, not full.
    repeat (10) begin
      @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_full", {31'd0, full}, 32'd0);
    end
    rst = 1'b0;

    // Single byte 0x55: start 0, then 1,0,1,0,1,0,1,0, [parity 0], stop 1.
`ifdef OUTPUT_BLK_PARITY_EN
    pat55 = 11'b100_1010_1010;
`else
    pat55 = 11'b010_1010_1010;
`endif
    send_and_check(8'h55, pat55, "single55");
    repeat (5) @(negedge clk);

    // Burst on alternate cycles, then an overflow write while full.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    burst_b = '{8'h55, 8'h33, 8'h0F, 8'h3C, 8'hC3};
    for (int i = 0; i < 5; i++) begin
      set = 1'b1;
      din = burst_b[i];
      @(negedge clk);
      set = 1'b0;
      @(negedge clk);
    end
    check("burst_full", {31'd0, full}, 32'd1);
    set = 1'b1;
    din = 8'hAA;
    @(negedge clk);
    set = 1'b0;
    check("overflow_full", {31'd0, full}, 32'd1);
    repeat (5 * FRAME_CYC + 20) @(negedge clk);
    check_rx(burst_b, "burst_rx");
    check("burst_drained_full", {31'd0, full}, 32'd0);

    // set held high 3 cycles: 3 bytes, including a write+pop in one cycle.
    rx_q.delete();
    held_b = '{8'h81, 8'h7E, 8'h00};
    set = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = held_b[i];
      @(negedge clk);
    end
    set = 1'b0;
    check("held_not_full", {31'd0, full}, 32'd0);
    repeat (3 * FRAME_CYC + 20) @(negedge clk);
    check_rx(held_b, "held_rx");

    // Mid-frame reset with 3 bytes still queued.
    rx_q.delete();
    set = 1'b1;
    din = 8'h11; @(negedge clk);
    din = 8'h22; @(negedge clk);
    din = 8'h33; @(negedge clk);
    din = 8'h44; @(negedge clk);
    set = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_full", {31'd0, full}, 32'd0);
    repeat (4 * FRAME_CYC) @(negedge clk);
    check("midreset_no_frames", rx_q.size(), 32'd0);
    check("midreset_tx_idle", {31'd0, tx}, 32'd1);

`ifdef OUTPUT_BLK_PARITY_EN
    // 0x07 has three ones: parity bit 1, 110-cycle frame.
    send_and_check(8'h07, 11'b110_0000_1110, "parity07");
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
